mem16_seq_ctrl: RTL and testbench

//  Sequencer for the 16x4 decimal-digit SRAM (write port takes a one-hot 10-bit digit code).

---
 rtl/mem16_seq_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_mem16_seq_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem16_seq_ctrl.sv
// Sequencer for a 16x4 decimal-digit SRAM: records keypad digits, clears the array
// and plays it back one digit every HOLD_CYC cycles. All SRAM control pins are registered.
module mem16_seq_ctrl #(
    parameter int HOLD_CYC = 25_000_000
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [9:0] KEY_IN,
    input  logic       CLR,
    input  logic       PLAY,
    output logic       MEM_EN,
    output logic       MEM_WR,
    output logic       MEM_RD,
    output logic [3:0] MEM_A,
    output logic [9:0] MEM_D,
    input  logic [3:0] MEM_Q,
    output logic [3:0] DISP_VAL,
    output logic       DISP_VALID,
    output logic [4:0] COUNT,
    output logic       FULL,
    output logic       BUSY,
    output logic       KEY_DROP
);

    localparam int HW = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;
    // Hold counter starts at 0 after the display update; PLAY_RD itself is the final cycle of each digit.
    localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_CYC >= 2) ? HOLD_CYC - 2 : 0);
    localparam logic [9:0] DIGIT0 = 10'b00_0000_0001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_CLEAR,
        S_PLAY_RD,
        S_PLAY_HOLD
    } state_t;

    state_t        state_reg;
    logic [9:0]    kprev_reg;
    logic [3:0]    wptr_reg;
    logic [3:0]    rptr_reg;
    logic [3:0]    cnt_reg;
    logic [HW-1:0] hold_reg;
    logic [4:0]    count_reg;
    logic [3:0]    disp_val_reg;
    logic          disp_valid_reg;
    logic          key_drop_reg;
    logic          mem_en_reg;
    logic          mem_wr_reg;
    logic          mem_rd_reg;
    logic [3:0]    mem_a_reg;
    logic [9:0]    mem_d_reg;

    logic       key_onehot;
    logic       press;
    logic       full;
    logic       hold_done;
    logic [4:0] rptr_inc;

    // A press is the rising edge of exactly one key; chords and held keys never count.
    assign key_onehot = (KEY_IN != 10'd0) && ((KEY_IN & (KEY_IN - 10'd1)) == 10'd0);
    assign press      = key_onehot && (kprev_reg == 10'd0);
    assign full       = (count_reg == 5'd16);
    assign rptr_inc   = {1'b0, rptr_reg} + 5'd1;
    assign hold_done  = ((state_reg == S_PLAY_RD) && (HOLD_CYC == 1)) ||
                        ((state_reg == S_PLAY_HOLD) && (hold_reg == HOLD_LAST));

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_reg      <= S_IDLE;
            kprev_reg      <= '0;
            wptr_reg       <= '0;
            rptr_reg       <= '0;
            cnt_reg        <= '0;
            hold_reg       <= '0;
            count_reg      <= '0;
            disp_val_reg   <= '0;
            disp_valid_reg <= 1'b0;
            key_drop_reg   <= 1'b0;
            mem_en_reg     <= 1'b0;
            mem_wr_reg     <= 1'b0;
            mem_rd_reg     <= 1'b0;
            mem_a_reg      <= '0;
            mem_d_reg      <= '0;
        end else begin
            kprev_reg    <= KEY_IN;
            mem_en_reg   <= 1'b0;
            mem_wr_reg   <= 1'b0;
            mem_rd_reg   <= 1'b0;
            mem_a_reg    <= '0;
            mem_d_reg    <= '0;
            key_drop_reg <= press && (state_reg != S_IDLE);

            case (state_reg)
                S_IDLE: begin
                    if (CLR) begin
                        state_reg    <= S_CLEAR;
                        cnt_reg      <= '0;
                        mem_en_reg   <= 1'b1;
                        mem_wr_reg   <= 1'b1;
                        mem_d_reg    <= DIGIT0;
                        key_drop_reg <= press;
                    end else if (PLAY && (count_reg != 5'd0)) begin
                        state_reg    <= S_PLAY_RD;
                        rptr_reg     <= '0;
                        mem_en_reg   <= 1'b1;
                        mem_rd_reg   <= 1'b1;
                        key_drop_reg <= press;
                    end else if (press) begin
                        if (full) begin
                            key_drop_reg <= 1'b1;
                        end else begin
                            state_reg  <= S_WRITE;
                            mem_en_reg <= 1'b1;
                            mem_wr_reg <= 1'b1;
                            mem_a_reg  <= wptr_reg;
                            mem_d_reg  <= KEY_IN;
                        end
                    end
                end

                S_WRITE: begin
                    wptr_reg <= wptr_reg + 4'd1;
                    if (!full) begin
                        count_reg <= count_reg + 5'd1;
                    end
                    state_reg <= S_IDLE;
                end

                S_CLEAR: begin
                    if (cnt_reg == 4'd15) begin
                        state_reg      <= S_IDLE;
                        wptr_reg       <= '0;
                        count_reg      <= '0;
                        disp_valid_reg <= 1'b0;
                    end else begin
                        cnt_reg    <= cnt_reg + 4'd1;
                        mem_en_reg <= 1'b1;
                        mem_wr_reg <= 1'b1;
                        mem_a_reg  <= cnt_reg + 4'd1;
                        mem_d_reg  <= DIGIT0;
                    end
                end

                S_PLAY_RD, S_PLAY_HOLD: begin
                    if (state_reg == S_PLAY_RD) begin
                        disp_val_reg   <= MEM_Q;
                        disp_valid_reg <= 1'b1;
                        hold_reg       <= '0;
                        state_reg      <= S_PLAY_HOLD;
                    end else begin
                        hold_reg <= hold_reg + 1'b1;
                    end
                    if (hold_done) begin
                        rptr_reg <= rptr_reg + 4'd1;
                        if (rptr_inc == count_reg) begin
                            state_reg <= S_IDLE;
                        end else begin
                            state_reg  <= S_PLAY_RD;
                            mem_en_reg <= 1'b1;
                            mem_rd_reg <= 1'b1;
                            mem_a_reg  <= rptr_reg + 4'd1;
                        end
                    end
                end

                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign MEM_EN     = mem_en_reg;
    assign MEM_WR     = mem_wr_reg;
    assign MEM_RD     = mem_rd_reg;
    assign MEM_A      = mem_a_reg;
    assign MEM_D      = mem_d_reg;
    assign DISP_VAL   = disp_val_reg;
    assign DISP_VALID = disp_valid_reg;
    assign COUNT      = count_reg;
    assign FULL       = full;
    assign BUSY       = (state_reg != S_IDLE);
    assign KEY_DROP   = key_drop_reg;

endmodule

// File: tb/tb_mem16_seq_ctrl.sv
// Bench for mem16_seq_ctrl: directed scenarios plus random keypad/CLR/PLAY/reset traffic,
// predicted by a cycle-stamped event model and checked by an independent monitor.
module tb_mem16_seq_ctrl;

    localparam int H = 4;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [9:0] KEY_IN;
    logic       CLR;
    logic       PLAY;
    logic       MEM_EN, MEM_WR, MEM_RD;
    logic [3:0] MEM_A;
    logic [9:0] MEM_D;
    logic [3:0] MEM_Q;
    logic [3:0] DISP_VAL;
    logic       DISP_VALID;
    logic [4:0] COUNT;
    logic       FULL, BUSY, KEY_DROP;

    always #5 CLK = ~CLK;

    mem16_seq_ctrl #(.HOLD_CYC(H)) dut (
        .CLK(CLK), .Reset(Reset), .KEY_IN(KEY_IN), .CLR(CLR), .PLAY(PLAY),
        .MEM_EN(MEM_EN), .MEM_WR(MEM_WR), .MEM_RD(MEM_RD), .MEM_A(MEM_A), .MEM_D(MEM_D),
        .MEM_Q(MEM_Q), .DISP_VAL(DISP_VAL), .DISP_VALID(DISP_VALID), .COUNT(COUNT),
        .FULL(FULL), .BUSY(BUSY), .KEY_DROP(KEY_DROP)
    );

    // SRAM device: one-hot write code stored as a 4-bit digit, asynchronous read
    function automatic logic [3:0] enc(input logic [9:0] d);
        enc = 4'hF;
        for (int i = 0; i < 10; i++) if (d == (10'd1 << i)) enc = 4'(i);
    endfunction

    logic [3:0] sram [16];
    always @(posedge CLK) if (MEM_EN && MEM_WR) sram[MEM_A] <= enc(MEM_D);
    assign MEM_Q = (MEM_EN && MEM_RD) ? sram[MEM_A] : 4'h0;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct { int c; logic [3:0] a; logic [9:0] d; } wr_t;
    typedef struct { int c; logic [3:0] v; } dp_t;
    wr_t wq[$];
    int  dq[$];
    dp_t pq[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: what the sequencer must do, in terms of event times
    int         busy_until = 0;
    int         m_count = 0;
    int         m_wptr = 0;
    logic [9:0] m_kprev = '0;
    int         m_mem [16];
    logic       m_valid = 1'b0;
    int         m_disp = 0;

    task automatic model(input logic [9:0] key, input logic clr, input logic play, input logic rst);
        int  p;
        bit  pr;
        p = cyc + 1;
        if (rst) begin
            wq.delete(); dq.delete(); pq.delete();
            busy_until = p + 1; m_count = 0; m_wptr = 0; m_kprev = '0;
            m_valid = 1'b0; m_disp = 0;
            return;
        end
        pr = ($countones(key) == 1) && (m_kprev == 10'd0);
        m_kprev = key;
        if (p < busy_until) begin
            if (pr) dq.push_back(p);
        end else if (clr) begin
            for (int i = 0; i < 16; i++) begin
                wq.push_back('{c: p + i, a: 4'(i), d: 10'h001});
                m_mem[i] = 0;
            end
            m_count = 0; m_wptr = 0; m_valid = 1'b0;
            busy_until = p + 17;
            if (pr) dq.push_back(p);
        end else if (play && m_count > 0) begin
            for (int i = 0; i < m_count; i++) pq.push_back('{c: p + 1 + i * H, v: 4'(m_mem[i])});
            m_valid = 1'b1; m_disp = m_mem[m_count - 1];
            busy_until = p + 1 + m_count * H;
            if (pr) dq.push_back(p);
        end else if (pr) begin
            if (m_count == 16) begin
                dq.push_back(p);
            end else begin
                wq.push_back('{c: p, a: 4'(m_wptr), d: key});
                m_mem[m_wptr] = $clog2(int'(key));
                m_wptr = (m_wptr + 1) % 16;
                m_count++;
                busy_until = p + 2;
            end
        end
    endtask

    // Monitor: compares every observed DUT event against the head of its queue
    logic prev_rd = 1'b0;
    wr_t  mw;
    dp_t  mp;
    int   md;
    always @(negedge CLK) begin
        if (Reset !== 1'b1) begin
            if (MEM_WR === 1'b1) begin
                if (wq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write @cycle %0d: got A=%0d D=%h, expected no write", cyc, MEM_A, MEM_D);
                end else begin
                    mw = wq.pop_front();
                    chk("write_cycle", cyc, mw.c);
                    chk("write_addr", MEM_A, mw.a);
                    chk("write_data", MEM_D, mw.d);
                    chk("write_en_rd", {MEM_EN, MEM_RD}, 2'b10);
                    $display("write  cycle %0d A=%0d D=%h", cyc, MEM_A, MEM_D);
                end
            end
            if (KEY_DROP === 1'b1) begin
                if (dq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_drop @cycle %0d: got KEY_DROP=1, expected 0", cyc);
                end else begin
                    md = dq.pop_front();
                    chk("drop_cycle", cyc, md);
                    $display("drop   cycle %0d", cyc);
                end
            end
            if (prev_rd) begin
                if (pq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_disp @cycle %0d: got DISP_VAL=%0d, expected none", cyc, DISP_VAL);
                end else begin
                    mp = pq.pop_front();
                    chk("disp_cycle", cyc, mp.c);
                    chk("disp_val", DISP_VAL, mp.v);
                    chk("disp_valid", DISP_VALID, 1);
                    $display("disp   cycle %0d digit %0d", cyc, DISP_VAL);
                end
            end
        end
        prev_rd = (MEM_RD === 1'b1) && (Reset !== 1'b1);
    end

    task automatic step(input logic [9:0] key, input logic clr, input logic play, input logic rst);
        @(negedge CLK);
        #1;
        KEY_IN = key; CLR = clr; PLAY = play; Reset = rst;
        model(key, clr, play, rst);
    endtask

    task automatic wait_idle();
        while (cyc < busy_until) step('0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic press(input int d);
        step(10'd1 << d, 1'b0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0, 1'b0);
        wait_idle();
    endtask

    task automatic status_check();
        chk("busy", BUSY, 0);
        chk("count", COUNT, m_count);
        chk("full", FULL, m_count == 16);
        chk("disp_valid_idle", DISP_VALID, m_valid);
        chk("disp_val_idle", DISP_VAL, m_disp);
        chk("mem_idle", {MEM_EN, MEM_WR, MEM_RD, MEM_A, MEM_D}, 0);
        $display("status cycle %0d COUNT=%0d FULL=%0d VALID=%0d", cyc, COUNT, FULL, DISP_VALID);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] held;
        int         left;
        logic [9:0] key;
        Reset = 1'b1; KEY_IN = '0; CLR = 1'b0; PLAY = 1'b0;
        for (int i = 0; i < 16; i++) m_mem[i] = 0;

        // reset state
        repeat (3) step('0, 1'b0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b0, 1'b0);
        chk("reset_drop", KEY_DROP, 0);
        wait_idle();
        status_check();

        // held key -> single write; chord -> nothing
        repeat (3) step(10'h004, 1'b0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0, 1'b0);
        wait_idle();
        status_check();
        repeat (2) step(10'h006, 1'b0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0, 1'b0);
        status_check();

        // playback of 2,3,7,9
        press(3); press(7); press(9);
        step('0, 1'b0, 1'b1, 1'b0);
        wait_idle();
        status_check();

        // fill to 16 and drop the 17th
        while (m_count < 16) press($urandom_range(0, 9));
        status_check();
        press(5);
        status_check();

        // clear, refill 5, clear again; PLAY then ignored
        step('0, 1'b1, 1'b0, 1'b0);
        wait_idle();
        for (int i = 0; i < 5; i++) press(i + 4);
        step('0, 1'b1, 1'b0, 1'b0);
        wait_idle();
        status_check();
        step('0, 1'b0, 1'b1, 1'b0);
        step('0, 1'b0, 1'b0, 1'b0);
        status_check();

        // press during playback, then reset mid-playback
        press(1); press(8); press(6);
        step('0, 1'b0, 1'b1, 1'b0);
        repeat (3) step('0, 1'b0, 1'b0, 1'b0);
        step(10'h100, 1'b0, 1'b0, 1'b0);
        repeat (2) step('0, 1'b0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b0, 1'b0);
        status_check();

        // random traffic
        held = '0; left = 0;
        for (int n = 0; n < 2500; n++) begin
            if (left > 0) begin
                left--; key = held;
            end else begin
                case ($urandom_range(0, 9))
                    4, 5, 6, 7: begin
                        held = 10'd1 << $urandom_range(0, 9);
                        left = $urandom_range(0, 2);
                        key  = held;
                    end
                    8: key = (10'd1 << $urandom_range(0, 9)) | (10'd1 << $urandom_range(0, 9));
                    default: key = '0;
                endcase
            end
            step(key, $urandom_range(0, 99) == 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 299) == 0);
            if (n % 100 == 99) begin
                wait_idle();
                step('0, 1'b0, 1'b0, 1'b0);
                status_check();
            end
        end

        wait_idle();
        repeat (3) step('0, 1'b0, 1'b0, 1'b0);
        chk("write_q_empty", wq.size(), 0);
        chk("drop_q_empty", dq.size(), 0);
        chk("disp_q_empty", pq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
